// File: rtl/mips_defs.sv
// Shared definitions for the fetch-side instruction memory loader.
package mips_defs;

    localparam int LENGTH = 32;
    localparam logic [LENGTH-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// UART byte stream in, instruction memory write port out.
interface program_loader_if #(
    parameter int LENGTH = mips_defs::LENGTH
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [LENGTH-1:0] instruction_to_write;
    logic [LENGTH-1:0] address_to_write;
    logic              write_enable;

    modport master (
        input  rx_data,
        input  rx_valid,
        output instruction_to_write,
        output address_to_write,
        output write_enable
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  instruction_to_write,
        input  address_to_write,
        input  write_enable
    );

endinterface

// File: rtl/byte_packer.sv
// Shifts bytes into a 32-bit big-endian word; word_ready flags the byte that completes it.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0] byte_cnt;
    logic       accept;

    assign accept     = enable && rx_valid;
    assign word_ready = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            word     <= {word[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Packs UART bytes into instructions, writes them to instruction memory and
// pulses start once the halt word has been stored.
module program_loader #(
    parameter int                LENGTH    = mips_defs::LENGTH,
    parameter int                MEM_DEPTH = 256,
    parameter logic [LENGTH-1:0] HALT_WORD = mips_defs::HALT_WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_request,
    program_loader_if.master bus,
    output logic             start,
    output logic             loading,
    output logic             overflow
);

    import mips_defs::*;

    localparam int              CNT_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_DEPTH - 1);

    loader_state_t    state;
    loader_state_t    state_next;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      word;
    logic             word_ready;
    logic             load_start;
    logic             is_halt;

    assign loading    = (state == RECV) || (state == WRITE);
    assign load_start = load_request && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign is_halt    = (LENGTH'(word) == HALT_WORD);

    // Packer stays enabled through WRITE so a byte arriving there starts the next word.
    byte_packer packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_start),
        .enable     (loading),
        .rx_data    (bus.rx_data),
        .rx_valid   (bus.rx_valid),
        .word       (word),
        .word_ready (word_ready)
    );

    assign bus.instruction_to_write = LENGTH'(word);
    assign bus.address_to_write     = LENGTH'(word_cnt);
    assign bus.write_enable         = (state == WRITE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load_request) state_next = RECV;
            RECV:    if (word_ready) state_next = WRITE;
            WRITE: begin
                if (is_halt)                    state_next = DONE;
                else if (word_cnt == LAST_ADDR) state_next = ERROR;
                else                            state_next = RECV;
            end
            DONE:    if (load_request) state_next = RECV;
            ERROR:   if (load_request) state_next = RECV;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            overflow <= 1'b0;
            start    <= 1'b0;
        end else begin
            state <= state_next;
            start <= (state == WRITE) && is_halt;
            if (load_start) begin
                word_cnt <= '0;
                overflow <= 1'b0;
            end else if ((state == WRITE) && !is_halt) begin
                if (word_cnt == LAST_ADDR) overflow <= 1'b1;
                else                       word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench: one loader at full depth, a second with MEM_DEPTH=4 for overflow.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       load_request = 1'b0;
    logic       sel = 1'b0;

    logic start0, loading0, overflow0;
    logic start1, loading1, overflow1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_byte_cyc = 0;

    logic [31:0] wr_data0[$], wr_addr0[$];
    int          wr_cyc0[$];
    logic [31:0] wr_data1[$], wr_addr1[$];
    int          starts0 = 0, starts1 = 0, start_cyc0 = 0;

    program_loader_if #(.LENGTH(32)) bus0 ();
    program_loader_if #(.LENGTH(32)) bus1 ();

    assign bus0.rx_data  = rx_data;
    assign bus1.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid && !sel;
    assign bus1.rx_valid = rx_valid && sel;

    program_loader #(.MEM_DEPTH(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_request (load_request && !sel),
        .bus          (bus0.master),
        .start        (start0),
        .loading      (loading0),
        .overflow     (overflow0)
    );

    program_loader #(.MEM_DEPTH(4)) dut_ovf (
        .clk          (clk),
        .reset        (reset),
        .load_request (load_request && sel),
        .bus          (bus1.master),
        .start        (start1),
        .loading      (loading1),
        .overflow     (overflow1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus0.write_enable) begin
            wr_data0.push_back(bus0.instruction_to_write);
            wr_addr0.push_back(bus0.address_to_write);
            wr_cyc0.push_back(cyc);
        end
        if (start0) begin
            starts0++;
            start_cyc0 = cyc;
        end
        if (bus1.write_enable) begin
            wr_data1.push_back(bus1.instruction_to_write);
            wr_addr1.push_back(bus1.address_to_write);
        end
        if (start1) starts1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_request = 1'b1;
        tick(1);
        load_request = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        last_byte_cyc = cyc;
        if (gap) begin
            rx_valid = 1'b0;
            tick(1);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) begin
            logic [31:0] v;
            v = w >> (8 * i);
            send_byte(v[7:0], gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int w0_cyc, h_cyc;

        // reset and idle behaviour
        tick(10);
        @(negedge clk);
        check("rst_instr", bus0.instruction_to_write, 32'h0);
        check("rst_addr", bus0.address_to_write, 32'h0);
        check("rst_we", {31'b0, bus0.write_enable}, 32'h0);
        check("rst_start", {31'b0, start0}, 32'h0);
        check("rst_loading", {31'b0, loading0}, 32'h0);
        check("rst_overflow", {31'b0, overflow0}, 32'h0);
        tick(1);
        reset = 1'b0;
        tick(1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        tick(3);
        check("idle_no_write", 32'(wr_data0.size()), 32'd0);
        check("idle_loading", {31'b0, loading0}, 32'h0);

        // single word plus halt
        pulse_load();
        @(negedge clk);
        check("load_loading", {31'b0, loading0}, 32'h1);
        tick(1);
        send_word(32'h1234_5678, 1'b1);
        w0_cyc = last_byte_cyc;
        send_word(32'hFFFF_FFFF, 1'b1);
        h_cyc = w0_cyc;
        h_cyc = last_byte_cyc;
        tick(4);
        check("single_count", 32'(wr_data0.size()), 32'd2);
        check("single_d0", wr_data0[0], 32'h1234_5678);
        check("single_a0", wr_addr0[0], 32'd0);
        check("single_lat", 32'(wr_cyc0[0]), 32'(w0_cyc));
        check("single_d1", wr_data0[1], 32'hFFFF_FFFF);
        check("single_a1", wr_addr0[1], 32'd1);
        check("single_starts", 32'(starts0), 32'd1);
        check("single_start_lat", 32'(start_cyc0), 32'(h_cyc + 1));
        check("single_loading", {31'b0, loading0}, 32'h0);
        check("done_hold_instr", bus0.instruction_to_write, 32'hFFFF_FFFF);
        check("done_hold_addr", bus0.address_to_write, 32'd1);

        // reload from DONE with back-to-back bytes
        wr_data0.delete(); wr_addr0.delete(); wr_cyc0.delete();
        pulse_load();
        send_word(32'h0102_0304, 1'b0);
        send_word(32'hA55A_C33C, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        rx_valid = 1'b0;
        tick(4);
        check("b2b_count", 32'(wr_data0.size()), 32'd3);
        check("b2b_d0", wr_data0[0], 32'h0102_0304);
        check("b2b_a0", wr_addr0[0], 32'd0);
        check("b2b_d1", wr_data0[1], 32'hA55A_C33C);
        check("b2b_a1", wr_addr0[1], 32'd1);
        check("b2b_d2", wr_data0[2], 32'hFFFF_FFFF);
        check("b2b_a2", wr_addr0[2], 32'd2);
        check("reload_starts", 32'(starts0), 32'd2);

        // reset mid-word discards the partial word
        wr_data0.delete(); wr_addr0.delete(); wr_cyc0.delete();
        pulse_load();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("midrst_no_write", 32'(wr_data0.size()), 32'd0);
        check("midrst_no_start", 32'(starts0), 32'd2);
        check("midrst_loading", {31'b0, loading0}, 32'h0);
        pulse_load();
        send_word(32'hAABB_CCDD, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        tick(4);
        check("midrst_count", 32'(wr_data0.size()), 32'd2);
        check("midrst_d0", wr_data0[0], 32'hAABB_CCDD);
        check("midrst_a0", wr_addr0[0], 32'd0);
        check("midrst_d1", wr_data0[1], 32'hFFFF_FFFF);
        check("midrst_starts", 32'(starts0), 32'd3);

        // overflow on the 4-word instance
        sel = 1'b1;
        pulse_load();
        for (int i = 1; i <= 5; i++) send_word({4{8'(i)}}, 1'b1);
        tick(4);
        check("ovf_count", 32'(wr_data1.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_d%0d", i), wr_data1[i], {4{8'(i + 1)}});
            check($sformatf("ovf_a%0d", i), wr_addr1[i], 32'(i));
        end
        check("ovf_flag", {31'b0, overflow1}, 32'h1);
        check("ovf_no_start", 32'(starts1), 32'd0);
        check("ovf_loading", {31'b0, loading1}, 32'h0);
        pulse_load();
        @(negedge clk);
        check("ovf_cleared", {31'b0, overflow1}, 32'h0);
        check("ovf_reload_loading", {31'b0, loading1}, 32'h1);
        check("ovf_other_untouched", 32'(starts0), 32'd3);
        sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory load interface of instruction_fetch.
- Receives a byte stream from the debug UART receiver and packs each four bytes into one 32-bit big-endian instruction.
- Drives instruction_to_write, address_to_write and write_enable into the fetch stage's instruction memory.
- Ends the load with a halt word, then pulses start so the pipeline begins fetching at address 0.

Parameters:
- LENGTH, 32, instruction and address width.
- MEM_DEPTH, 256, instruction memory depth in words; addresses 0..MEM_DEPTH-1.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle.
- load_request  input  1  level; begin a new load while in IDLE or DONE.
- instruction_to_write  output  LENGTH  packed instruction.
- address_to_write  output  LENGTH  word index; zero-extended counter.
- write_enable  output  1  one-cycle write strobe to instruction memory.
- start  output  1  one-cycle pulse; program loaded, fetch may run.
- loading  output  1  high in RECV and WRITE.
- overflow  output  1  sticky; program exceeded MEM_DEPTH words.

Behaviour:
- Reset values: every output 0, state IDLE, byte counter 0, word counter 0, shift register 0.
- States:
  - IDLE: all outputs low. load_request -> RECV; clear byte counter, word counter, overflow and shift register.
  - RECV: on each rx_valid, shift register = {shift[23:0], rx_data}, so the first byte received becomes bits [31:24]. byte_cnt++. When the 4th byte arrives, byte_cnt -> 0 and the next state is WRITE. rx_valid with no load in progress is ignored.
  - WRITE (exactly one cycle):
    - write_enable=1, instruction_to_write=shift, address_to_write=word_cnt.
    - If shift==HALT_WORD -> DONE; the halt word is stored in memory.
    - Else if word_cnt==MEM_DEPTH-1 -> ERROR with overflow=1; the last word is still written.
    - Else word_cnt++ and return to RECV.
  - DONE: start=1 in the first DONE cycle only, then held 0. instruction_to_write and address_to_write hold their last values. load_request -> RECV (reload).
  - ERROR: start is never asserted; overflow stays 1. load_request -> RECV and clears overflow.
- Latency:
  - 4th byte strobe at edge N -> write_enable high during cycle N+1.
  - Halt word write at cycle N+1 -> start pulse at cycle N+2.
- rx_valid arriving in the WRITE cycle is accepted into the cleared shift path. The RECV logic is also active in WRITE, so no byte is lost at full back-to-back rate.
- write_enable is never asserted outside WRITE. address_to_write is stable whenever write_enable=1.
- Reset mid-load aborts immediately: write_enable falls the next cycle and no start pulse occurs. A partial word is discarded.
- Counter widths: byte_cnt 2 bits, wraps naturally. word_cnt is $clog2(MEM_DEPTH) bits and never wraps, because ERROR is taken first.
- Asserting load_request while in RECV/WRITE has no effect.

Decomposition:
- Shared package mips_defs:
  - LENGTH.
  - HALT_WORD.
  - Loader state encoding: IDLE=0, RECV=1, WRITE=2, DONE=3, ERROR=4 (3 bits).
- One natural sub-module, byte_packer: shift register plus 2-bit counter, with outputs word and word_ready.
- FSM and address counter stay in program_loader.

Test Plan:
- Reset then idle: 10 cycles with reset=1 -> all outputs 0. rx_valid pulses without load_request -> no write_enable.
- Single word plus halt: load_request, bytes 12 34 56 78, then FF FF FF FF.
  - Write 0x12345678 at address 0, then 0xFFFFFFFF at address 1.
  - One start pulse one cycle after the second write; loading falls.
- Back-to-back bytes: rx_valid high every cycle for 12 bytes (2 words + halt) -> three writes at addresses 0,1,2 with no dropped byte; data matches.
- Overflow: MEM_DEPTH=4, send 5 non-halt words.
  - Writes at addresses 0..3.
  - overflow=1 after the 4th write; start never pulses; 5th word ignored.
- Reset mid-word: send 2 bytes then assert reset.
  - No write occurs.
  - A new load of 0xAABBCCDD + halt writes 0xAABBCCDD at address 0; the stale bytes do not appear.
- Reload from DONE: after a completed load, load_request plus a new program -> address restarts at 0, second start pulse generated.
